// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One bit per cycle in CONV; the result is held in DONE until it is consumed.
module bin2bcd_seq_ctrl #(
    parameter int BIN_WIDTH  = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_WIDTH-1:0]    bin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    busy,
    output logic [15:0]             done_cnt
);

    localparam int BW = 4 * BCD_DIGITS;
    localparam int CW = $clog2(BIN_WIDTH + 1);

    function automatic bit digits_ok();
        longint p10 = 1;
        for (int i = 0; i < BCD_DIGITS; i++) p10 = p10 * 10;
        return p10 > ((longint'(1) << BIN_WIDTH) - 1);
    endfunction

    if (!digits_ok()) begin : g_bad_digits
        $error("BCD_DIGITS too small for BIN_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [BIN_WIDTH-1:0]   bin_q, bin_d;
    logic [BW-1:0]          acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bcd_q, bcd_d;
    logic [15:0]            done_q, done_d;
    logic [BW-1:0]          adj;
    logic [BW+BIN_WIDTH-1:0] shifted;

    // Per-digit add-3 correction, no carry between digits
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (acc_q[4*i+:4] >= 4'd5) adj[4*i+:4] = acc_q[4*i+:4] + 4'd3;
        end
        shifted = {adj, bin_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = bin;
                    acc_d   = '0;
                    cnt_d   = CW'(BIN_WIDTH);
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d = shifted[BW+BIN_WIDTH-1:BIN_WIDTH];
                bin_d = shifted[BIN_WIDTH-1:0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    bcd_d   = shifted[BW+BIN_WIDTH-1:BIN_WIDTH];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    if (done_q != 16'hFFFF) done_d = done_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == CONV);
    assign out_valid = (state_q == DONE);
    assign bcd       = bcd_q;
    assign done_cnt  = done_q;

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// Scoreboard bench for bin2bcd_seq_ctrl: decimal reference model,
// directed latency/stall/reset cases and a full 0..255 sweep.
module tb_bin2bcd_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  bin;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd;
    logic        busy;
    logic [15:0] done_cnt;

    bin2bcd_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .bcd      (bcd),
        .busy     (busy),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          total = 0;
    int          passed = 0;
    int          hs = 0;
    bit          rand_stall = 0;
    logic [11:0] q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: compares every presented result against the queue head
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hs = 0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                chk("out_without_expect", out_valid, 0);
            end else begin
                chk("bcd", bcd, q[0]);
                if (out_ready) begin
                    void'(q.pop_front());
                    hs++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_stall) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input int v, input bit hold, output int acc);
        int n;
        n = 0;
        bin = 8'(v);
        in_valid = 1'b1;
        while (!in_ready && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("timeout_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        q.push_back(ref_bcd(v));
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int k, output int b);
        k = 0;
        b = 0;
        while (!out_valid && k < 100) begin
            if (busy) b++;
            @(posedge clk);
            #1;
            k++;
        end
        if (!out_valid) chk("timeout_out_valid", out_valid, 1);
    endtask

    initial begin
        int a1, a2, k, b, n;
        rst = 1'b1;
        in_valid = 1'b0;
        bin = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_done_cnt", done_cnt, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(0, 0, a1);
        wait_valid(k, b);
        chk("lat_0", k, 8);
        chk("busy_0", b, 8);
        @(posedge clk);
        #1;
        chk("done_cnt_1", done_cnt, 1);
        chk("out_valid_fall", out_valid, 0);

        send(255, 0, a1);
        wait_valid(k, b);
        chk("lat_255", k, 8);
        chk("busy_255", b, 8);
        @(posedge clk);
        #1;
        chk("bcd_retained", bcd, 12'h255);
        chk("done_cnt_2", done_cnt, 2);

        out_ready = 1'b0;
        send(99, 0, a1);
        wait_valid(k, b);
        for (int i = 0; i < 5; i++) begin
            chk("stall_bcd", bcd, 12'h099);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        chk("stall_done_cnt", done_cnt, 2);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_done_cnt", done_cnt, 3);
        chk("hs_out_valid", out_valid, 0);

        send(10, 1, a1);
        send(200, 0, a2);
        chk("b2b_interval", a2 - a1, 10);
        wait_valid(k, b);
        @(posedge clk);
        #1;
        chk("b2b_done_cnt", done_cnt, 5);

        send(123, 0, a1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_bcd", bcd, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done_cnt", done_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(123, 0, a1);
        wait_valid(k, b);
        chk("re_lat", k, 8);
        @(posedge clk);
        #1;
        chk("re_done_cnt", done_cnt, 1);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rand_stall = 1;
        for (int v = 0; v < 256; v++) send(v, 0, a1);
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        rand_stall = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        chk("sweep_drain", q.size(), 0);
        chk("sweep_hs", hs, 256);
        chk("sweep_done_cnt", done_cnt, 256);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
